spi_controller: RTL and testbench
=================================

// Module: spi_controller
//
// PURPOSE
//   SPI Mode 0 controller: the initiating end of the Mode 0 transfers the peripheral-side SPI core responds to.
//   Generates spi_cs_no/spi_sck_o from the system clock, shifts data_i out MSB-first on SDO and shifts SDI into data_o.
//   Sits between a word-level valid/ready request port and the board SPI pins.
//   Supports back-to-back words with CS held low, for multi-byte commands.
//
// PARAMETERS
//   DATA_WIDTH  8  bits per word, >= 2
//   SCK_DIV     2  clk_i cycles per SCK half-period, >= 1; also sets CS setup time and minimum CS-high gap
//
// PORTS
//   clk_i       in   1           system clock; the only clock
//   reset_i     in   1           asynchronous, active-high reset
//   start_i     in   1           request a word transfer; accepted on a clk_i edge where start_i && ready_o
//   hold_cs_i   in   1           sampled at accept: 1 = keep CS low after this word
//   release_i   in   1           in HELD: deassert CS (ignored in all other states)
//   data_i      in   DATA_WIDTH  word to transmit; sampled at accept
//   ready_o     out  1           1 in IDLE and HELD
//   data_o      out  DATA_WIDTH  last received word; updated only with done_o
//   done_o      out  1           one-cycle pulse: word complete, data_o valid
//   spi_cs_no   out  1           chip select, active low
//   spi_sck_o   out  1           serial clock, idles low
//   spi_sd_o    out  1           serial data out (controller -> peripheral)
//   spi_sd_i    in   1           serial data in (peripheral -> controller)
//
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, spi_cs_no=1, spi_sck_o=0, spi_sd_o=0, done_o=0, ready_o=1, data_o='0.
//   Outputs are registered. No SCK edge or done_o pulse is emitted for an aborted word.
//   States:
//   - IDLE: CS high.
//   - SETUP: CS low, SCK=0, SDO=MSB, for SCK_DIV cycles.
//   - SCK_HI: SCK=1 for SCK_DIV cycles.
//   - SCK_LO: SCK=0 for SCK_DIV cycles.
//   - HELD: CS low, SCK 0.
//   - GAP: CS high for SCK_DIV cycles, then IDLE.
//   Timing, with accept at edge T0 (IDLE or HELD -> SETUP, shift register <= data_i, bit counter <= DATA_WIDTH-1):
//   - Bit i (1..DATA_WIDTH): SCK rises at edge T0+(2i-1)*SCK_DIV.
//     At that same edge spi_sd_i is captured into the receive shift register (LSB end).
//   - SCK falls at T0+2i*SCK_DIV. For i<DATA_WIDTH, SDO advances to the next bit at that edge.
//   - At T0+2*DATA_WIDTH*SCK_DIV: SCK falls, data_o <= received word, done_o=1 for exactly one cycle.
//     Next state is HELD if the captured hold_cs_i=1, else GAP.
//   Latency: accept -> done_o = 2*DATA_WIDTH*SCK_DIV cycles (32 for the defaults).
//   HELD:
//   - start_i accepts a new word (-> SETUP, CS stays low).
//   - release_i -> GAP.
//   - start_i && release_i in the same cycle: start wins, release ignored.
//   start_i while ready_o=0 is ignored, not queued. data_i/hold_cs_i changes after accept have no effect.
//   The SDO value after the last bit is don't-care; drive the last bit held.
//   Counters: half-period counter width $clog2(SCK_DIV+1), counts SCK_DIV-1 down to 0; bit counter width $clog2(DATA_WIDTH).
//
// STRUCTURE
//   spi_pkg: typedef enum spi_ctl_state_t {IDLE, SETUP, SCK_HI, SCK_LO, HELD, GAP}; SPI_MODE0 constants.
//   Sub-module spi_clk_div: loadable half-period down-counter emitting a one-cycle 'tick'.
//   Everything else (FSM, tx/rx shift registers, bit counter) stays in this module.
//
// TESTING
//   1. Loopback (spi_sd_i=spi_sd_o), defaults, send 0xA5, hold_cs_i=0.
//      -> done_o 32 cycles after accept, data_o=0xA5, 8 SCK pulses each 2 cycles high.
//      -> CS high 2 cycles, then ready_o=1.
//   2. Peripheral model returns 0x3C (MSB preloaded at CS fall, changes on SCK fall); send 0xC3.
//      -> model receives 0xC3, data_o=0x3C.
//   3. Send 0x01 with hold_cs_i=1, then 0x02 with hold_cs_i=1, then release_i.
//      -> CS low continuously across both words, 2 done_o pulses, CS high 2 cycles after release, ready_o=1.
//   4. reset_i asserted after the 4th SCK rise.
//      -> same cycle: CS=1, SCK=0, ready_o=1, no done_o; a following 0x5A transfer completes correctly.
//   5. start_i pulsed while busy, and start_i && release_i together in HELD.
//      -> busy start ignored (exactly one done_o); simultaneous case starts the new word with CS staying low.
//   6. SCK_DIV=1 and DATA_WIDTH=16, loopback 0xBEEF.
//      -> done_o at 32 cycles, data_o=0xBEEF, SCK toggles every cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI Mode 0 controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HELD,
    GAP
  } spi_ctl_state_t;

  // Mode 0: SCK idles low; CS is active low
  localparam logic SPI_CPOL    = 1'b0;
  localparam logic SPI_CS_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter; tick_c marks the last cycle of a half-period.
module spi_clk_div #(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(SCK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so an idle divider keeps ticking harmlessly
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI Mode 0 controller: word-level valid/ready request port to SPI pins,
// MSB-first, with optional CS hold between back-to-back words.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SCK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  hold_cs_i,
  input  logic                  release_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  done_o,
  output logic                  spi_cs_no,
  output logic                  spi_sck_o,
  output logic                  spi_sd_o,
  input  logic                  spi_sd_i
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_WIDTH - 1);

  spi_ctl_state_t state_q, state_nxt;

  logic [DATA_WIDTH-1:0] tx_q, rx_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  hold_q;

  logic tick_c, load_c, accept_c, last_bit_c;
  logic rise_c, fall_c;
  logic cs_d, sck_d, ready_d, done_d;

  spi_clk_div #(.SCK_DIV(SCK_DIV)) u_clk_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load    (load_c),
    .tick_c  (tick_c)
  );

  assign last_bit_c = (bit_cnt_q == '0);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next-state logic; in HELD a start takes priority over release
  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_nxt = SETUP;
          accept_c  = 1'b1;
        end
      end
      SETUP:  if (tick_c) state_nxt = SCK_HI;
      SCK_HI: begin
        if (tick_c) begin
          if (last_bit_c) state_nxt = hold_q ? HELD : GAP;
          else            state_nxt = SCK_LO;
        end
      end
      SCK_LO: if (tick_c) state_nxt = SCK_HI;
      HELD: begin
        if (start_i) begin
          state_nxt = SETUP;
          accept_c  = 1'b1;
        end else if (release_i) begin
          state_nxt = GAP;
        end
      end
      GAP:     if (tick_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode from the upcoming state, registered below
  always_comb begin
    load_c  = (state_nxt != state_q);
    rise_c  = (state_nxt == SCK_HI) && (state_q != SCK_HI);
    fall_c  = (state_q == SCK_HI) && (state_nxt == SCK_LO);
    done_d  = (state_q == SCK_HI) && tick_c && last_bit_c;
    cs_d    = ((state_nxt == IDLE) || (state_nxt == GAP)) ? SPI_CS_IDLE : ~SPI_CS_IDLE;
    sck_d   = (state_nxt == SCK_HI) ? ~SPI_CPOL : SPI_CPOL;
    ready_d = (state_nxt == IDLE) || (state_nxt == HELD);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spi_cs_no <= SPI_CS_IDLE;
      spi_sck_o <= SPI_CPOL;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
    end else begin
      spi_cs_no <= cs_d;
      spi_sck_o <= sck_d;
      ready_o   <= ready_d;
      done_o    <= done_d;
    end
  end

  // Shift registers and bit counter; SDO keeps the last bit after the word
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      hold_q    <= 1'b0;
      data_o    <= '0;
    end else begin
      if (accept_c) begin
        tx_q      <= data_i;
        bit_cnt_q <= LAST_IDX;
        hold_q    <= hold_cs_i;
      end
      if (rise_c) rx_q <= {rx_q[DATA_WIDTH-2:0], spi_sd_i};
      if (fall_c) begin
        tx_q      <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - BIT_W'(1);
      end
      if (done_d) data_o <= rx_q;
    end
  end

  assign spi_sd_o = tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: default 8-bit/div-2 instance plus a 16-bit/div-1 instance.
module tb_spi_controller;

  localparam int W0 = 8;
  localparam int D0 = 2;
  localparam int W1 = 16;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic          start, hold_cs, rel, ready, done, cs_n, sck, sdo, sdi;
  logic [W0-1:0] data_in, data_out;

  // Wide, fast instance (always loopback)
  logic          start1, hold1, rel1, ready1, done1, cs1, sck1, sdo1;
  logic [W1-1:0] data_in1, data_out1;

  // Peripheral model: MSB presented at CS fall, advances on SCK fall, samples on SCK rise
  logic [7:0] per_word = 8'h00;
  logic [7:0] per_rx   = 8'h00;
  int         per_idx  = 0;
  logic       per_sdo;
  bit         use_lb   = 1'b1;

  always @(posedge cs_n or negedge sck) begin
    if (cs_n) per_idx <= 0;
    else      per_idx <= per_idx + 1;
  end
  always @(posedge sck) per_rx <= {per_rx[6:0], sdo};
  assign per_sdo = (per_idx < 8) ? per_word[3'(7 - per_idx)] : 1'b0;
  assign sdi = use_lb ? sdo : per_sdo;

  spi_controller dut0 (
    .clk_i(clk), .reset_i(rst), .start_i(start), .hold_cs_i(hold_cs), .release_i(rel),
    .data_i(data_in), .ready_o(ready), .data_o(data_out), .done_o(done),
    .spi_cs_no(cs_n), .spi_sck_o(sck), .spi_sd_o(sdo), .spi_sd_i(sdi)
  );

  spi_controller #(.DATA_WIDTH(W1), .SCK_DIV(D1)) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1), .hold_cs_i(hold1), .release_i(rel1),
    .data_i(data_in1), .ready_o(ready1), .data_o(data_out1), .done_o(done1),
    .spi_cs_no(cs1), .spi_sck_o(sck1), .spi_sd_o(sdo1), .spi_sd_i(sdo1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One word on dut0, started from the #1-after-edge point with ready high
  task automatic word0(input logic [7:0] tx, input logic [7:0] pw, input bit lb,
                       input logic [7:0] exp_rx, input bit hold, input bit rel_too,
                       input bit poke);
    int cyc, rises, hi_run, bad_w, cs_bad, dn, extra;
    logic prev_sck;
    logic [7:0] got;
    per_word = pw;
    use_lb   = lb;
    chk("ready_before", 32'(ready), 32'd1);
    data_in = tx; hold_cs = hold; start = 1'b1; rel = rel_too;
    @(posedge clk); #1;
    start = 1'b0; rel = 1'b0; data_in = ~tx; hold_cs = ~hold;
    cyc = 0; rises = 0; hi_run = 0; bad_w = 0; cs_bad = 0; dn = -1; got = '0;
    prev_sck = sck;
    if (cs_n !== 1'b0 || sck !== 1'b0) cs_bad++;
    while (dn < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (sck && !prev_sck) rises++;
      if (sck) hi_run++;
      else begin
        if (prev_sck && hi_run != D0) bad_w++;
        hi_run = 0;
      end
      prev_sck = sck;
      if (done) begin
        dn  = cyc;
        got = data_out;
      end else if (cs_n !== 1'b0) cs_bad++;
      if (poke) begin
        start   = (cyc == 5);
        data_in = 8'h3F;
      end
    end
    chk("latency", 32'(dn), 32'(2 * W0 * D0));
    chk("data_o", 32'(got), 32'(exp_rx));
    chk("sck_rises", 32'(rises), 32'(W0));
    chk("sck_high_width", 32'(bad_w), 32'd0);
    chk("cs_low_during_word", 32'(cs_bad), 32'd0);
    if (!lb) chk("periph_rx", 32'(per_rx), 32'(tx));
    if (hold) begin
      chk("held_cs", 32'(cs_n), 32'd0);
      chk("held_ready", 32'(ready), 32'd1);
    end else begin
      chk("gap_cs0", 32'(cs_n), 32'd1);
      chk("gap_ready0", 32'(ready), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("gap_cs1", 32'(cs_n), 32'd1);
      chk("gap_ready1", 32'(ready), 32'd0);
      @(posedge clk); #1;
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_cs", 32'(cs_n), 32'd1);
      if (poke) begin
        extra = 0;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          if (done || !cs_n) extra++;
        end
        chk("busy_start_ignored", 32'(extra), 32'd0);
      end
    end
  endtask

  // One loopback word on dut1
  task automatic word1(input logic [15:0] tx);
    int cyc, rises, tog_bad, cs_bad, dn;
    logic prev;
    logic [15:0] got;
    data_in1 = tx; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; data_in1 = ~tx;
    cyc = 0; rises = 0; tog_bad = 0; cs_bad = 0; dn = -1; got = '0;
    prev = sck1;
    if (cs1 !== 1'b0) cs_bad++;
    while (dn < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (sck1 && !prev) rises++;
      prev = sck1;
      if (sck1 !== ((cyc % 2) == 1)) tog_bad++;
      if (done1) begin
        dn  = cyc;
        got = data_out1;
      end else if (cs1 !== 1'b0) cs_bad++;
    end
    chk("w16_latency", 32'(dn), 32'(2 * W1 * D1));
    chk("w16_data_o", 32'(got), 32'(tx));
    chk("w16_rises", 32'(rises), 32'(W1));
    chk("w16_toggle", 32'(tog_bad), 32'd0);
    chk("w16_cs_low", 32'(cs_bad), 32'd0);
    chk("w16_gap_cs", 32'(cs1), 32'd1);
    chk("w16_gap_ready", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    chk("w16_idle_ready", 32'(ready1), 32'd1);
    chk("w16_done_pulse", 32'(done1), 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] pw;
    bit         lb;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int rises;
    int cyc;
    logic prev;
    logic [7:0] rtx, rpw;
    bit rlb;

    tbl[0] = '{tx: 8'hA5, pw: 8'h00, lb: 1'b1, exp_rx: 8'hA5};
    tbl[1] = '{tx: 8'hC3, pw: 8'h3C, lb: 1'b0, exp_rx: 8'h3C};
    tbl[2] = '{tx: 8'hFF, pw: 8'h00, lb: 1'b0, exp_rx: 8'h00};
    tbl[3] = '{tx: 8'h00, pw: 8'hFF, lb: 1'b0, exp_rx: 8'hFF};
    tbl[4] = '{tx: 8'h80, pw: 8'h01, lb: 1'b0, exp_rx: 8'h01};
    tbl[5] = '{tx: 8'h7E, pw: 8'h81, lb: 1'b1, exp_rx: 8'h7E};

    rst = 1'b1;
    start = 1'b0; hold_cs = 1'b0; rel = 1'b0; data_in = '0;
    start1 = 1'b0; hold1 = 1'b0; rel1 = 1'b0; data_in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ready_w16", 32'(ready1), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: loopback and peripheral words
    foreach (tbl[i]) word0(tbl[i].tx, tbl[i].pw, tbl[i].lb, tbl[i].exp_rx, 1'b0, 1'b0, 1'b0);

    // Held CS across two words, then release
    word0(8'h01, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    word0(8'h02, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    chk("rel_cs0", 32'(cs_n), 32'd1);
    chk("rel_ready0", 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_cs1", 32'(cs_n), 32'd1);
    chk("rel_ready1", 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_idle_ready", 32'(ready), 32'd1);

    // Reset after the 4th SCK rise, then a clean transfer
    use_lb = 1'b1;
    data_in = 8'h99; hold_cs = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 0; cyc = 0; prev = sck;
    while (rises < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (sck && !prev) rises++;
      prev = sck;
    end
    chk("reach_4th_rise", 32'(rises), 32'd4);
    rst = 1'b1;
    #1;
    chk("arst_cs", 32'(cs_n), 32'd1);
    chk("arst_sck", 32'(sck), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_done", 32'(done), 32'd0);
    word0(8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Busy start ignored; start+release together in HELD starts a new word
    word0(8'hE7, 8'h00, 1'b1, 8'hE7, 1'b0, 1'b0, 1'b1);
    word0(8'h11, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    word0(8'h22, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);

    // Random words against the model: loopback echoes tx, peripheral returns its word
    for (int i = 0; i < 16; i++) begin
      rtx = 8'($urandom);
      rpw = 8'($urandom);
      rlb = 1'($urandom_range(0, 1));
      word0(rtx, rpw, rlb, rlb ? rtx : rpw, 1'b0, 1'b0, 1'b0);
    end

    // 16-bit, SCK_DIV=1 instance
    word1(16'hBEEF);
    for (int i = 0; i < 4; i++) word1(16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
